decoder_syndrome: RTL and testbench

// - Receive side of the encoder link: accepts codeword beats, ENC_SYM GF(2^EGF_DIM) symbols per beat.
// - Computes the PAR_SYM Reed-Solomon syndromes per codeword by Horner accumulation.
// - Forwards message beats, strips parity beats and flags each codeword as clean or corrupted.
// - Sits between the channel and the (future) error locator/corrector.

---
 rtl/decoder_pkg.sv | 44 ++++
 rtl/decoder_syndrome_if.sv | 34 +++
 rtl/decoder_syn_cell.sv | 39 +++
 rtl/decoder_syndrome.sv | 79 +++++++
 tb/tb_decoder_syndrome.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared constants, types and GF(2^EGF_DIM) helpers for the RS syndrome decoder.
// Helpers are used to elaborate constant multipliers only.
package decoder_pkg;

    localparam int unsigned EGF_DIM   = 8;
    localparam logic [EGF_DIM:0] EGF_POLY = 9'h11D;
    localparam int unsigned ENC_SYM   = 4;
    localparam int unsigned CW_BEATS  = 8;
    localparam int unsigned PAR_SYM   = 4;
    localparam int unsigned FCR       = 0;

    localparam int unsigned BEAT_W    = ENC_SYM * EGF_DIM;
    localparam int unsigned SYN_W     = PAR_SYM * EGF_DIM;
    localparam int unsigned PAR_BEATS = PAR_SYM / ENC_SYM;
    localparam int unsigned MSG_BEATS = CW_BEATS - PAR_BEATS;
    localparam int unsigned CNT_W     = (CW_BEATS > 1) ? $clog2(CW_BEATS) : 1;
    localparam int unsigned GF_ORDER  = (1 << EGF_DIM) - 1;

    typedef logic [EGF_DIM-1:0] sym_t;
    typedef logic [BEAT_W-1:0]  beat_t;
    typedef logic [SYN_W-1:0]   syn_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // Shift-and-add product modulo EGF_POLY.
    function automatic sym_t gf_mul(sym_t a, sym_t b);
        sym_t p = '0;
        sym_t x = a;
        for (int i = 0; i < int'(EGF_DIM); i++) begin
            if (b[i]) p = p ^ x;
            x = x[EGF_DIM-1] ? (sym_t'(x << 1) ^ EGF_POLY[EGF_DIM-1:0]) : sym_t'(x << 1);
        end
        return p;
    endfunction

    // alpha^e with alpha = x, exponent reduced modulo the field order.
    function automatic sym_t gf_pow(int e);
        sym_t p = sym_t'(1);
        int   n = e % int'(GF_ORDER);
        if (n < 0) n = n + int'(GF_ORDER);
        for (int i = 0; i < n; i++) p = gf_mul(p, sym_t'(2));
        return p;
    endfunction

endpackage

// File: rtl/decoder_syndrome_if.sv
// Codeword-in / message-out bus of the syndrome decoder.
// DECODER_ERR_CNT_EN adds the err_cnt status signal.
interface decoder_syndrome_if;
    import decoder_pkg::*;

    beat_t       enc_data;
    logic        enc_valid;
    beat_t       dec_data;
    logic        dec_valid;
    logic        dec_last;
    logic        cw_done;
    logic        cw_err;
    syn_t        cw_syn;
`ifdef DECODER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    modport master (
        output enc_data, enc_valid,
        input  dec_data, dec_valid, dec_last, cw_done, cw_err, cw_syn
`ifdef DECODER_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  enc_data, enc_valid,
        output dec_data, dec_valid, dec_last, cw_done, cw_err, cw_syn
`ifdef DECODER_ERR_CNT_EN
        , output err_cnt
`endif
    );

endinterface

// File: rtl/decoder_syn_cell.sv
// One Horner syndrome accumulator S_j = c(alpha^R), a whole beat per step.
// syn_next_c is the value including the current beat, used for codeword close-out.
module decoder_syn_cell
    import decoder_pkg::*;
#(
    parameter int unsigned R = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  beat_t beat,
    input  logic  valid,
    input  logic  first,
    output sym_t  syn_next_c
);

    localparam sym_t SHIFT_K = gf_pow(int'(R * ENC_SYM));

    sym_t acc;
    sym_t term_c [ENC_SYM];

    // Symbol 0 sits in the MSBs and carries the highest degree of the beat.
    for (genvar i = 0; i < int'(ENC_SYM); i++) begin : g_tap
        localparam sym_t TAP_K = gf_pow(int'(R * (ENC_SYM - 1 - i)));
        assign term_c[i] = gf_mul(beat[(ENC_SYM-1-i)*EGF_DIM +: EGF_DIM], TAP_K);
    end

    always_comb begin
        sym_t sum;
        sum = first ? '0 : gf_mul(acc, SHIFT_K);
        for (int i = 0; i < int'(ENC_SYM); i++) sum = sum ^ term_c[i];
        syn_next_c = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        acc <= '0;
        else if (valid) acc <= syn_next_c;
    end

endmodule

// File: rtl/decoder_syndrome.sv
// RS receive front end: counts beats, forwards message beats, drops parity and
// reports per-codeword syndromes. DECODER_ERR_CNT_EN adds a saturating error count.
module decoder_syndrome
    import decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    decoder_syndrome_if.slave bus
);

    cnt_t cnt;
    logic first_c;
    logic last_c;
    logic msg_c;
    logic msg_last_c;
    logic close_c;
    sym_t syn_next_c [PAR_SYM];
    syn_t syn_all_c;

    assign first_c    = (cnt == '0);
    assign last_c     = (cnt == cnt_t'(CW_BEATS - 1));
    assign msg_c      = (cnt <  cnt_t'(MSG_BEATS));
    assign msg_last_c = (cnt == cnt_t'(MSG_BEATS - 1));
    assign close_c    = bus.enc_valid && last_c;

    for (genvar j = 0; j < int'(PAR_SYM); j++) begin : g_syn
        decoder_syn_cell #(.R(FCR + j)) u_cell (
            .clk        (clk),
            .rst        (rst),
            .beat       (bus.enc_data),
            .valid      (bus.enc_valid),
            .first      (first_c),
            .syn_next_c (syn_next_c[j])
        );
        assign syn_all_c[(PAR_SYM-1-j)*EGF_DIM +: EGF_DIM] = syn_next_c[j];
    end

    // Beat position within the codeword; idle cycles hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (bus.enc_valid) cnt <= last_c ? '0 : cnt + cnt_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dec_data  <= '0;
            bus.dec_valid <= 1'b0;
            bus.dec_last  <= 1'b0;
        end else begin
            bus.dec_valid <= bus.enc_valid && msg_c;
            bus.dec_last  <= bus.enc_valid && msg_last_c;
            if (bus.enc_valid && msg_c) bus.dec_data <= bus.enc_data;
        end
    end

    // Syndromes include the closing beat; held until the next codeword closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cw_done <= 1'b0;
            bus.cw_err  <= 1'b0;
            bus.cw_syn  <= '0;
        end else begin
            bus.cw_done <= close_c;
            if (close_c) begin
                bus.cw_syn <= syn_all_c;
                bus.cw_err <= |syn_all_c;
            end
        end
    end

`ifdef DECODER_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.err_cnt <= '0;
        else if (close_c && (|syn_all_c) && (bus.err_cnt != 16'hFFFF))
            bus.err_cnt <= bus.err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_decoder_syndrome.sv
// Scoreboard bench for decoder_syndrome: builds RS codewords with its own encoder,
// predicts forwarded beats and syndromes, compares them as the DUT produces them.
module tb_decoder_syndrome;
    import decoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #1 clk = ~clk;

    decoder_syndrome_if bus ();
    decoder_syndrome dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { beat_t data; logic last; } dec_exp_t;
    typedef struct { syn_t syn; int done_cyc; } cw_exp_t;

    dec_exp_t dec_q [$];
    cw_exp_t  cw_q  [$];
    beat_t    cw    [CW_BEATS];
    int checks      = 0;
    int passed      = 0;
    int cyc         = 0;
    int exp_err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // MSB-first reduction, deliberately a different formulation from the RTL helper.
    function automatic sym_t tb_mul(sym_t a, sym_t b);
        sym_t p = '0;
        for (int i = int'(EGF_DIM) - 1; i >= 0; i--) begin
            p = p[EGF_DIM-1] ? (sym_t'(p << 1) ^ EGF_POLY[EGF_DIM-1:0]) : sym_t'(p << 1);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic sym_t tb_alpha(int e);
        sym_t p = sym_t'(1);
        for (int i = 0; i < e % 255; i++) p = tb_mul(p, sym_t'(2));
        return p;
    endfunction

    function automatic sym_t get_sym(int idx);
        beat_t b = cw[idx / int'(ENC_SYM)];
        return b[(int'(ENC_SYM) - 1 - idx % int'(ENC_SYM)) * int'(EGF_DIM) +: EGF_DIM];
    endfunction

    // Systematic encoder: parity = m(x)*x^PAR_SYM mod g(x).
    task automatic fill_parity();
        sym_t gl  [PAR_SYM+1];
        sym_t rem [PAR_SYM];
        sym_t root, fb;
        int   pidx;
        for (int k = 0; k <= int'(PAR_SYM); k++) gl[k] = '0;
        for (int k = 0; k < int'(PAR_SYM); k++)  rem[k] = '0;
        gl[0] = sym_t'(1);
        for (int j = 0; j < int'(PAR_SYM); j++) begin
            root = tb_alpha(int'(FCR) + j);
            for (int k = int'(PAR_SYM); k >= 1; k--) gl[k] = gl[k-1] ^ tb_mul(root, gl[k]);
            gl[0] = tb_mul(root, gl[0]);
        end
        for (int s = 0; s < int'(MSG_BEATS * ENC_SYM); s++) begin
            fb = get_sym(s) ^ rem[0];
            for (int k = 0; k < int'(PAR_SYM) - 1; k++)
                rem[k] = rem[k+1] ^ tb_mul(fb, gl[int'(PAR_SYM) - 1 - k]);
            rem[PAR_SYM-1] = tb_mul(fb, gl[0]);
        end
        for (int p = 0; p < int'(PAR_SYM); p++) begin
            pidx = int'(MSG_BEATS) + p / int'(ENC_SYM);
            cw[pidx][(int'(ENC_SYM) - 1 - p % int'(ENC_SYM)) * int'(EGF_DIM) +: EGF_DIM] = rem[p];
        end
    endtask

    // Symbol-serial evaluation of the received polynomial at alpha^(FCR+j).
    function automatic syn_t model_syn();
        syn_t r = '0;
        sym_t s, a;
        for (int j = 0; j < int'(PAR_SYM); j++) begin
            a = tb_alpha(int'(FCR) + j);
            s = '0;
            for (int k = 0; k < int'(CW_BEATS * ENC_SYM); k++) s = tb_mul(s, a) ^ get_sym(k);
            r[(int'(PAR_SYM) - 1 - j) * int'(EGF_DIM) +: EGF_DIM] = s;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.enc_valid = 1'b0;
        end
    endtask

    // Drives the first n_beats of cw[], optional gap after beat gap_after.
    task automatic send_cw(input int n_beats, input int gap_after, input int gap_len, input logic clean);
        cw_exp_t  c;
        dec_exp_t d;
        for (int b = 0; b < n_beats; b++) begin
            if (b == gap_after + 1) idle(gap_len);
            @(negedge clk);
            bus.enc_valid = 1'b1;
            bus.enc_data  = cw[b];
            if (b < int'(MSG_BEATS)) begin
                d.data = cw[b];
                d.last = (b == int'(MSG_BEATS) - 1);
                dec_q.push_back(d);
            end
            if (b == int'(CW_BEATS) - 1) begin
                c.syn      = clean ? '0 : model_syn();
                c.done_cyc = cyc + 1;
                if (|c.syn) exp_err_cnt++;
                cw_q.push_back(c);
            end
        end
    endtask

    task automatic load_alt_msg();
        for (int b = 0; b < int'(MSG_BEATS); b++) cw[b] = (b % 2 == 0) ? 32'h01234567 : 32'h89abcdef;
        fill_parity();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (dec_q.size() != 0 || cw_q.size() != 0); i++) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        dec_exp_t d;
        cw_exp_t  c;
        if (!rst) begin
            if (bus.dec_valid === 1'b1) begin
                if (dec_q.size() == 0) check_eq("dec_valid_spurious", 64'(bus.dec_valid), 64'd0);
                else begin
                    d = dec_q.pop_front();
                    check_eq("dec_data", 64'(bus.dec_data), 64'(d.data));
                    check_eq("dec_last", 64'(bus.dec_last), 64'(d.last));
                end
            end
            if (bus.cw_done === 1'b1) begin
                if (cw_q.size() == 0) check_eq("cw_done_spurious", 64'(bus.cw_done), 64'd0);
                else begin
                    c = cw_q.pop_front();
                    check_eq("cw_syn", 64'(bus.cw_syn), 64'(c.syn));
                    check_eq("cw_err", 64'(bus.cw_err), 64'(|c.syn));
                    check_eq("cw_done_cycle", 64'(cyc), 64'(c.done_cyc));
                end
            end
        end
    end

    initial begin
        int rb, rs;
        sym_t rv;
        bus.enc_valid = 1'b0;
        bus.enc_data  = '0;

        #22 rst = 1'b1;
        #2;
        check_eq("rst_dec_data",  64'(bus.dec_data),  64'd0);
        check_eq("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check_eq("rst_dec_last",  64'(bus.dec_last),  64'd0);
        check_eq("rst_cw_done",   64'(bus.cw_done),   64'd0);
        check_eq("rst_cw_err",    64'(bus.cw_err),    64'd0);
        check_eq("rst_cw_syn",    64'(bus.cw_syn),    64'd0);
`ifdef DECODER_ERR_CNT_EN
        check_eq("rst_err_cnt",   64'(bus.err_cnt),   64'd0);
`endif
        #3 rst = 1'b0;

        // All-zero codeword.
        for (int b = 0; b < int'(CW_BEATS); b++) cw[b] = '0;
        send_cw(int'(CW_BEATS), -2, 0, 1'b1);

        // Back-to-back clean codewords: beat 0 lands in the cw_done cycle.
        load_alt_msg();
        repeat (3) send_cw(int'(CW_BEATS), -2, 0, 1'b1);
        idle(1);
        wait_drain();

        // Single-symbol error in symbol 0 of beat 0.
        load_alt_msg();
        cw[0] = cw[0] ^ 32'h01000000;
        send_cw(int'(CW_BEATS), -2, 0, 1'b0);
        idle(1);
        wait_drain();
        check_eq("corrupt_s0",  64'(bus.cw_syn[SYN_W-1 -: EGF_DIM]), 64'h01);
        check_eq("corrupt_err", 64'(bus.cw_err), 64'd1);

        // Clean codeword with a 3-cycle gap after beat 2.
        load_alt_msg();
        send_cw(int'(CW_BEATS), 2, 3, 1'b1);
        idle(1);
        wait_drain();
        check_eq("gap_err", 64'(bus.cw_err), 64'd0);

        // Partial codeword aborted by reset, then a clean codeword.
        load_alt_msg();
        send_cw(4, -2, 0, 1'b1);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_mid_done", 64'(bus.cw_done), 64'd0);
        rst = 1'b0;
        send_cw(int'(CW_BEATS), -2, 0, 1'b1);
        idle(1);
        wait_drain();

        // Random messages with one random nonzero symbol error, back to back.
        repeat (3) begin
            for (int b = 0; b < int'(MSG_BEATS); b++) cw[b] = $urandom;
            fill_parity();
            rb = int'($urandom_range(CW_BEATS - 1));
            rs = int'($urandom_range(ENC_SYM - 1));
            rv = sym_t'($urandom_range(255, 1));
            cw[rb][(int'(ENC_SYM) - 1 - rs) * int'(EGF_DIM) +: EGF_DIM] =
                cw[rb][(int'(ENC_SYM) - 1 - rs) * int'(EGF_DIM) +: EGF_DIM] ^ rv;
            send_cw(int'(CW_BEATS), -2, 0, 1'b0);
        end
        load_alt_msg();
        send_cw(int'(CW_BEATS), -2, 0, 1'b1);
        idle(2);
        wait_drain();

        check_eq("drain_dec", 64'(dec_q.size()), 64'd0);
        check_eq("drain_cw",  64'(cw_q.size()),  64'd0);
`ifdef DECODER_ERR_CNT_EN
        check_eq("err_cnt", 64'(bus.err_cnt), 64'(exp_err_cnt));
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
